load_store_unit: RTL and testbench

Data-memory access stage directly downstream of the ALU in the single-cycle CPU. It takes the ALU result as the effective address for LW/LH/LB/SW/SH/SB and runs a req/ack transaction on the data bus. It holds the CPU with `stall` until the access finishes, then returns aligned, extended load data for write-back.

---
 rtl/load_store_unit.sv | 152 +++++++++++++++
 tb/tb_load_store_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Data-memory access stage: runs one req/ack bus transaction per load/store and stalls the CPU until it ends.
// Optional LSU_ALIGN_CHECK_EN flags misaligned half/word accesses instead of silently aligning them.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        load_unsigned,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        addr_err,
  output logic        bus_timeout,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       size_p0;
  logic [1:0]       lane_p0;
  logic             uns_p0;
  logic             access;
  logic             addr_err_c;
  logic [31:0]      addr_al;
  logic [3:0]       be_c;
  logic [31:0]      wdata_c;

  function automatic logic [31:0] extract(input logic [31:0] rdata, input logic [1:0] size,
                                          input logic [1:0] lane, input logic uns);
    logic [31:0]        shifted;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    shifted = rdata >> {lane, 3'b000};
    b_s     = shifted[7:0];
    h_s     = shifted[15:0];
    case (size)
      2'b00:   extract = uns ? {24'b0, shifted[7:0]}  : {{24{b_s[7]}}, b_s};
      2'b01:   extract = uns ? {16'b0, shifted[15:0]} : {{16{h_s[15]}}, h_s};
      default: extract = rdata;
    endcase
  endfunction

  assign access = mem_read | mem_write;

`ifdef LSU_ALIGN_CHECK_EN
  logic misalign;
  assign misalign   = ((mem_size == 2'b01) & alu_result[0]) | (mem_size[1] & (|alu_result[1:0]));
  assign addr_err_c = rst_n & (state == IDLE) & access & misalign;
  assign addr_al    = alu_result;
`else
  assign addr_err_c = 1'b0;
  // Without the check, misaligned halves/words are quietly rounded down to their natural boundary.
  always_comb begin
    addr_al = alu_result;
    if (mem_size == 2'b01) addr_al[0] = 1'b0;
    if (mem_size[1])       addr_al[1:0] = 2'b00;
  end
`endif

  assign addr_err = addr_err_c;
  assign stall    = rst_n & (((state == IDLE) & access & ~addr_err_c) | (state == REQ));

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = store_data;
    case (mem_size)
      2'b00: begin
        be_c    = 4'b0001 << addr_al[1:0];
        wdata_c = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_c    = addr_al[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      size_p0     <= 2'b00;
      lane_p0     <= 2'b00;
      uns_p0      <= 1'b0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_be      <= '0;
      bus_wdata   <= '0;
      done        <= 1'b0;
      load_data   <= '0;
      bus_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access && !addr_err_c) begin
            state       <= REQ;
            cnt         <= '0;
            size_p0     <= mem_size;
            lane_p0     <= addr_al[1:0];
            uns_p0      <= load_unsigned;
            bus_req     <= 1'b1;
            bus_we      <= mem_write;
            bus_addr    <= {addr_al[31:2], 2'b00};
            bus_be      <= be_c;
            bus_wdata   <= wdata_c;
            bus_timeout <= 1'b0;
          end
        end
        // Ack is tested first so an ack landing on the abort cycle still completes normally.
        REQ: begin
          if (bus_ack) begin
            load_data <= extract(bus_rdata, size_p0, lane_p0, uns_p0);
            bus_req   <= 1'b0;
            done      <= 1'b1;
            state     <= RESP;
          end else if (TIMEOUT_CYCLES != 0 && cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            load_data   <= '0;
            bus_timeout <= 1'b1;
            bus_req     <= 1'b0;
            done        <= 1'b1;
            state       <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, randomized accesses against a reference model, reset/timeout sequences.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0, load_unsigned = 1'b0;
  logic [1:0]  mem_size = 2'b10;
  logic [31:0] alu_result = '0, store_data = '0;
  logic        stall, done, addr_err, bus_timeout, bus_req, bus_we;
  logic [31:0] load_data, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .load_unsigned(load_unsigned), .alu_result(alu_result), .store_data(store_data),
    .stall(stall), .done(done), .load_data(load_data), .addr_err(addr_err),
    .bus_timeout(bus_timeout), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a, sd, rd;
    int          ack_at;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_ld;
    logic        e_to;
    int          e_nreq;
  } vec_t;

  typedef struct {
    logic        t0_stall, stall_bad, done, done_after, to, we;
    logic [31:0] addr, wdata, ld;
    logic [3:0]  be;
    int          nreq;
  } obs_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: expected bus fields and result from the access rules, using plain integer arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    longint unsigned eff, lane, nbytes, mask, val;
    eff = v.a;
    if (v.sz == 2'd1) eff = eff - (eff % 2);
    if (v.sz >= 2'd2) eff = eff - (eff % 4);
    lane   = eff % 4;
    nbytes = (v.sz == 2'd0) ? 1 : (v.sz == 2'd1) ? 2 : 4;
    r.e_addr = 32'(eff - lane);
    r.e_be   = (nbytes == 4) ? 4'hF : 4'(((1 << nbytes) - 1) << lane);
    if (nbytes == 1)      r.e_wdata = 32'((v.sd % 256) * 64'h01010101);
    else if (nbytes == 2) r.e_wdata = 32'((v.sd % 65536) * 64'h00010001);
    else                  r.e_wdata = v.sd;
    if (v.ack_at < 0 || v.ack_at >= TO) begin
      r.e_to = 1'b1; r.e_ld = '0; r.e_nreq = TO;
    end else begin
      r.e_to = 1'b0; r.e_nreq = v.ack_at + 1;
      if (nbytes == 4) r.e_ld = v.rd;
      else begin
        mask = (64'd1 << (8 * nbytes)) - 1;
        val  = (longint'(v.rd) >> (8 * lane)) & mask;
        if (!v.uns && val >= (mask + 1) / 2) val = val + (64'hFFFF_FFFF - mask);
        r.e_ld = 32'(val);
      end
    end
    return r;
  endfunction

  task automatic run_access(input vec_t v, output obs_t o);
    o = '{default: '0};
    @(negedge clk);
    mem_write = v.wr; mem_read = ~v.wr; mem_size = v.sz; load_unsigned = v.uns;
    alu_result = v.a; store_data = v.sd;
    #1 o.t0_stall = stall;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0; alu_result = $urandom; store_data = $urandom;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (bus_req) begin
        o.nreq++;
        if (!stall) o.stall_bad = 1'b1;
        if (c == 0) begin
          o.addr = bus_addr; o.be = bus_be; o.wdata = bus_wdata; o.we = bus_we;
        end
        if (c == v.ack_at) begin bus_ack = 1'b1; bus_rdata = v.rd; end
        @(posedge clk); #1;
        bus_ack = 1'b0; bus_rdata = $urandom;
      end else begin
        o.done = done; o.ld = load_data; o.to = bus_timeout;
        if (stall) o.stall_bad = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    o.done_after = done;
  endtask

  task automatic check_obs(input string tag, input vec_t e, input obs_t o);
    chk({tag, ".addr"}, o.addr, e.e_addr);
    chk({tag, ".be"}, 32'(o.be), 32'(e.e_be));
    chk({tag, ".we"}, 32'(o.we), 32'(e.wr));
    if (e.wr) chk({tag, ".wdata"}, o.wdata, e.e_wdata);
    else      chk({tag, ".load_data"}, o.ld, e.e_ld);
    chk({tag, ".timeout"}, 32'(o.to), 32'(e.e_to));
    chk({tag, ".req_cycles"}, 32'(o.nreq), 32'(e.e_nreq));
    chk({tag, ".done"}, 32'(o.done), 32'd1);
    chk({tag, ".done_pulse"}, 32'(o.done_after), 32'd0);
    chk({tag, ".stall_t0"}, 32'(o.t0_stall), 32'd1);
    chk({tag, ".stall_window"}, 32'(o.stall_bad), 32'd0);
  endtask

  vec_t  tbl[12];
  vec_t  v;
  obs_t  o;
  logic [31:0] ld_before;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    //         wr  sz    uns  addr           sdata          rdata          ack e_addr         e_be     e_wdata        e_ld           to  nreq
    tbl[0]  = '{0, 2'd2, 0, 32'h0000_0010, 32'h0,          32'hDEAD_BEEF, 0, 32'h10, 4'b1111, 32'h0,          32'hDEAD_BEEF, 0, 1};
    tbl[1]  = '{0, 2'd0, 0, 32'h0000_0013, 32'h0,          32'h80FF_0000, 0, 32'h10, 4'b1000, 32'h0,          32'hFFFF_FF80, 0, 1};
    tbl[2]  = '{0, 2'd0, 1, 32'h0000_0013, 32'h0,          32'h80FF_0000, 0, 32'h10, 4'b1000, 32'h0,          32'h0000_0080, 0, 1};
    tbl[3]  = '{0, 2'd1, 0, 32'h0000_0012, 32'h0,          32'h80FF_0000, 0, 32'h10, 4'b1100, 32'h0,          32'hFFFF_80FF, 0, 1};
    tbl[4]  = '{1, 2'd0, 0, 32'h0000_0021, 32'h0000_00A5, 32'h0,          0, 32'h20, 4'b0010, 32'hA5A5_A5A5, 32'h0,          0, 1};
    tbl[5]  = '{1, 2'd1, 0, 32'h0000_0022, 32'h0000_1234, 32'h0,          0, 32'h20, 4'b1100, 32'h1234_1234, 32'h0,          0, 1};
    tbl[6]  = '{0, 2'd2, 0, 32'h0000_0044, 32'h0,          32'h0123_4567, 2, 32'h44, 4'b1111, 32'h0,          32'h0123_4567, 0, 3};
    tbl[7]  = '{0, 2'd1, 1, 32'h0000_0010, 32'h0,          32'h0000_8001, 1, 32'h10, 4'b0011, 32'h0,          32'h0000_8001, 0, 2};
    tbl[8]  = '{0, 2'd1, 0, 32'h0000_0010, 32'h0,          32'h0000_8001, 0, 32'h10, 4'b0011, 32'h0,          32'hFFFF_8001, 0, 1};
    tbl[9]  = '{0, 2'd3, 0, 32'h0000_0008, 32'h0,          32'hCAFE_F00D, 0, 32'h08, 4'b1111, 32'h0,          32'hCAFE_F00D, 0, 1};
    tbl[10] = '{0, 2'd2, 0, 32'h0000_0050, 32'h0,          32'h1111_2222, -1, 32'h50, 4'b1111, 32'h0,         32'h0,          1, 4};
    tbl[11] = '{0, 2'd0, 1, 32'h0000_0061, 32'h0,          32'h0000_C300, 3, 32'h60, 4'b0010, 32'h0,          32'h0000_00C3, 0, 4};

    // Reset state, with a request already asserted to prove stall is forced low.
    mem_read = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.bus_req", 32'(bus_req), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.load_data", load_data, 32'd0);
    chk("rst.bus_timeout", 32'(bus_timeout), 32'd0);
    chk("rst.addr_err", 32'(addr_err), 32'd0);
    chk("rst.bus_be", 32'(bus_be), 32'd0);
    mem_read = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_access(tbl[i], o);
      check_obs($sformatf("vec%0d", i), tbl[i], o);
    end

    // Ack outside REQ must be ignored.
    ld_before = load_data;
    @(negedge clk); bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
    repeat (2) @(negedge clk);
    chk("stray_ack.done", 32'(done), 32'd0);
    chk("stray_ack.bus_req", 32'(bus_req), 32'd0);
    chk("stray_ack.load_data", load_data, ld_before);
    bus_ack = 1'b0;

    // Misaligned word load.
`ifdef LSU_ALIGN_CHECK_EN
    @(negedge clk);
    mem_read = 1'b1; mem_size = 2'd2; alu_result = 32'h2;
    #1;
    chk("mis.addr_err", 32'(addr_err), 32'd1);
    chk("mis.stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    mem_read = 1'b0;
    @(negedge clk);
    chk("mis.bus_req", 32'(bus_req), 32'd0);
    chk("mis.load_data", load_data, ld_before);
`else
    v = '{0, 2'd2, 0, 32'h2, 32'h0, 32'h7777_8888, 0, 32'h0, 4'b1111, 32'h0, 32'h7777_8888, 0, 1};
    run_access(v, o);
    check_obs("mis", v, o);
`endif

    // Randomized accesses checked against the model.
    for (int i = 0; i < 40; i++) begin
      v.wr = 1'($urandom); v.sz = 2'($urandom); v.uns = 1'($urandom);
      v.a = $urandom & 32'h0000_FFFF; v.sd = $urandom; v.rd = $urandom;
      v.ack_at = int'($urandom_range(0, 6)) - 1;
`ifdef LSU_ALIGN_CHECK_EN
      if (v.sz == 2'd1) v.a[0] = 1'b0;
      if (v.sz[1])      v.a[1:0] = 2'b00;
`endif
      v = model(v);
      run_access(v, o);
      check_obs($sformatf("rnd%0d", i), v, o);
    end

    // Reset in the middle of REQ: outputs drop without a clock edge, late ack ignored.
    @(negedge clk);
    mem_read = 1'b1; mem_size = 2'd2; alu_result = 32'h30;
    @(posedge clk); #1;
    mem_read = 1'b0;
    @(negedge clk);
    chk("midrst.req_before", 32'(bus_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.bus_req", 32'(bus_req), 32'd0);
    chk("midrst.stall", 32'(stall), 32'd0);
    chk("midrst.load_data", load_data, 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("midrst.late_done", 32'(done), 32'd0);
    chk("midrst.late_req", 32'(bus_req), 32'd0);
    chk("midrst.late_load", load_data, 32'd0);
    bus_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
